// File: rtl/seq_mul_pkg.sv
// Shared definitions for the seq_mul iterative multiplier: FSM state encoding
// and the iteration-counter width helper.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must reach WIDTH-1; sized with one spare code.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mul_abs.sv
// Conditional two's-complement negate. Used for operand magnitudes and, at
// double width, for restoring the product sign.
module seq_mul_abs #(
  parameter int W = 4
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  // The most-negative input maps onto itself, which reads correctly as an unsigned magnitude.
  assign dout = neg ? -din : din;

endmodule

// File: rtl/seq_mul.sv
// Iterative radix-2 shift-add multiplier with valid/ready on both sides.
// Optional accumulate mode is enabled by defining SEQ_MUL_ACC_EN.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready=1
// CALC    | one shift-add step per cycle, WIDTH cycles
// DONE    | result on mul, held until out_ready
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
`ifdef SEQ_MUL_ACC_EN
  input  logic               acc_clr,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] mul,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t          state, state_nxt;
  logic            accept;
  logic            last;
  logic            neg;
  logic [WIDTH-1:0] a_mag, b_mag, mplier;
  logic [PW-1:0]   mcand, pp, pp_add, res;
  logic [CW-1:0]   cnt;

  seq_mul_abs #(.W(WIDTH)) u_abs_a (.din(a), .neg(sgn & a[WIDTH-1]), .dout(a_mag));
  seq_mul_abs #(.W(WIDTH)) u_abs_b (.din(b), .neg(sgn & b[WIDTH-1]), .dout(b_mag));
  seq_mul_abs #(.W(PW))    u_sign  (.din(pp_add), .neg(neg), .dout(res));

  assign pp_add = mplier[0] ? (pp + mcand) : pp;
  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = in_valid & in_ready;

  always_ff @(posedge ck) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_CALC;
      end
      ST_CALC: begin
        busy = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? ST_CALC : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

`ifdef SEQ_MUL_ACC_EN
  logic          acc_clr_q;
  logic [PW-1:0] acc;
  assign mul = acc;
`else
  logic [PW-1:0] prod;
  assign mul = prod;
`endif

  always_ff @(posedge ck) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      pp     <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
`ifdef SEQ_MUL_ACC_EN
      acc_clr_q <= 1'b0;
      acc       <= '0;
`else
      prod   <= '0;
`endif
    end else if (accept) begin
      mcand  <= PW'(a_mag);
      mplier <= b_mag;
      pp     <= '0;
      cnt    <= '0;
      neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef SEQ_MUL_ACC_EN
      acc_clr_q <= acc_clr;
`endif
    end else if (state == ST_CALC) begin
      pp     <= pp_add;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      // Result register loads on the final step so mul is valid the cycle DONE is entered.
      if (last) begin
`ifdef SEQ_MUL_ACC_EN
        acc <= acc_clr_q ? res : (acc + res);
`else
        prod <= res;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Directed self-checking bench for seq_mul at WIDTH=4 with a result scoreboard.
module tb_seq_mul;
  localparam int W = 4;

  logic           ck = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           sgn = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] mul;
  logic           busy;
`ifdef SEQ_MUL_ACC_EN
  logic           acc_clr = 1'b1;
  logic [2*W-1:0] acc_m = '0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t_acc = 0;
  int t_prev = 0;
  logic [2*W-1:0] sb[$];

  seq_mul #(.WIDTH(W)) dut (
    .ck(ck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn),
`ifdef SEQ_MUL_ACC_EN
    .acc_clr(acc_clr),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .mul(mul), .busy(busy)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    longint px, py;
    logic [63:0] p;
    px = s ? longint'($signed(x)) : longint'(x);
    py = s ? longint'($signed(y)) : longint'(y);
    p = px * py;
    return p[2*W-1:0];
  endfunction

  // Score any handshake about to happen at the coming edge, then advance one cycle.
  task automatic tick();
    logic [2*W-1:0] e;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = sb.pop_front();
        check("result", mul, e);
      end
    end
    @(posedge ck); #1;
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                       input logic [2*W-1:0] exp);
    int n;
    n = 0;
    a = ia; b = ib; sgn = is; in_valid = 1'b1;
    while (!in_ready && n < 40) begin tick(); n++; end
    check("accept_wait", in_ready, 1);
    t_prev = t_acc;
    t_acc = cyc;
`ifdef SEQ_MUL_ACC_EN
    acc_m = acc_clr ? exp : acc_m + exp;
    sb.push_back(acc_m);
`else
    sb.push_back(exp);
`endif
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sgn = 1'($urandom);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge ck); #1; n++; end
    check("latency", cyc - t_acc, W + 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin tick(); n++; end
    check("drain", sb.size(), 0);
  endtask

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is,
                    input logic [2*W-1:0] exp);
    issue(ia, ib, is, exp);
    wait_valid();
    drain();
  endtask

  logic [W-1:0] pa[4] = '{4'd3, 4'hE, 4'd7, 4'hC};
  logic [W-1:0] pb[4] = '{4'd3, 4'd3, 4'h9, 4'hA};
  logic         ps[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    @(posedge ck); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mul", mul, 0);
    rst = 1'b0;
    @(posedge ck); #1;
    check("post_rst_in_ready", in_ready, 1);

    // unsigned basics, with busy/in_ready checked during CALC
    issue(4'd2, 4'd5, 1'b0, 8'd10);
    check("calc_busy", busy, 1);
    check("calc_in_ready", in_ready, 0);
    wait_valid();
    drain();
    op(4'd6, 4'd4, 1'b0, 8'd24);
    op(4'd1, 4'd7, 1'b0, 8'd7);
    op(4'd5, 4'd3, 1'b0, 8'd15);

    // signed corners
    op(4'hD, 4'd5, 1'b1, 8'hF1);
    op(4'h8, 4'h8, 1'b1, 8'h40);
    op(4'hF, 4'hF, 1'b0, 8'hE1);
    op(4'hF, 4'hF, 1'b1, 8'h01);
    op(4'h8, 4'd1, 1'b1, 8'hF8);

    // backpressure
    out_ready = 1'b0;
    issue(4'd2, 4'd5, 1'b0, 8'd10);
    wait_valid();
    for (int i = 0; i < 7; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_mul", mul, 8'd10);
      check("bp_in_ready", in_ready, 0);
      @(posedge ck); #1;
    end
    out_ready = 1'b1;
    tick();
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_idle_out_valid", out_valid, 0);
    check("bp_idle_busy", busy, 0);
    check("bp_sb_empty", sb.size(), 0);

    // back-to-back with in_valid held high
    for (int k = 0; k < 4; k++) begin
      issue(pa[k], pb[k], ps[k], ref_mul(pa[k], pb[k], ps[k]));
      in_valid = 1'b1;
      if (k > 0) check("b2b_spacing", t_acc - t_prev, W + 1);
    end
    in_valid = 1'b0;
    drain();

    // reset in the middle of a calculation
    issue(4'd6, 4'd4, 1'b0, 8'd24);
    @(posedge ck); #1;
    rst = 1'b1;
    @(posedge ck); #1;
    sb.delete();
`ifdef SEQ_MUL_ACC_EN
    acc_m = '0;
`endif
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_mul", mul, 0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) tick();
    op(4'd6, 4'd4, 1'b0, 8'd24);

`ifdef SEQ_MUL_ACC_EN
    acc_clr = 1'b1;
    op(4'd2, 4'd5, 1'b0, 8'd10);
    acc_clr = 1'b0;
    op(4'd6, 4'd4, 1'b0, 8'd24);
    op(4'hF, 4'd1, 1'b1, 8'hFF);
    op(4'hF, 4'hF, 1'b0, 8'd225);
    check("acc_wrap", mul, 8'd2);
    op(4'hF, 4'hF, 1'b0, 8'd225);
    check("acc_final", mul, 8'd227);
    acc_clr = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
